seq_booth_multiplier: RTL and testbench

Parametrised sequential radix-4 Booth multiplier; the next-generation replacement for the fixed 32×32 shift-accumulate multiplier in the arithmetic datapath. It adds a configurable operand width, a per-operation signed/unsigned mode, a start/busy/done handshake and a stall enable. It retires two multiplier bits per cycle and holds the full-width product until the next operation completes.

---
 rtl/seq_booth_multiplier.sv | 130 +++++++++++++
 tb/tb_seq_booth_multiplier.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier: sequential radix-4 Booth multiplier.
// Retires two multiplier bits per enabled cycle over a fixed WIDTH/2+1 iterations,
// with a start/busy/done handshake, a clock enable that stalls everything, and a
// product register that only changes on completion or reset.
module seq_booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     inputM,
    input  logic [WIDTH-1:0]     inputQ,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    localparam int EW    = WIDTH + 2;
    localparam int AW    = WIDTH + 3;
    localparam int NITER = WIDTH / 2 + 1;
    localparam int CW    = $clog2(NITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [CW-1:0] count;
    logic [AW-1:0] acc;
    logic [EW-1:0] mreg;
    logic [EW-1:0] qreg;
    logic          qguard;

    logic [EW-1:0] m_cap;
    logic [EW-1:0] q_cap;
    logic [AW-1:0] m_single;
    logic [AW-1:0] m_double;
    logic [AW-1:0] addend;
    logic [AW-1:0] sum;
    logic [AW-1:0] acc_next;
    logic [EW-1:0] q_next;
    logic          guard_next;
    logic          capture;
    logic          iterate;
    logic          last;

    // Operands are widened by two bits so the datapath can always treat them as signed.
    assign m_cap = signed_mode ? {{2{inputM[WIDTH-1]}}, inputM} : {2'b00, inputM};
    assign q_cap = signed_mode ? {{2{inputQ[WIDTH-1]}}, inputQ} : {2'b00, inputQ};

    assign capture = en && start && ((state == IDLE) || (state == DONE));
    assign iterate = en && (state == RUN);
    assign last    = (count == CW'(1));

    // The state register advances only on enabled cycles, so done stretches across stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (en) begin
            state <= next_state;
        end
    end

    // Next-state logic: start is honoured only in IDLE and DONE, never mid-run.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last)  next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs decode directly from the state.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Booth recoding of {Q[1:0], q-1} into 0, +-M or +-2M, then add and shift right by two.
    always_comb begin
        m_single = {mreg[EW-1], mreg};
        m_double = {mreg, 1'b0};
        addend   = '0;
        case ({qreg[1:0], qguard})
            3'b001, 3'b010: addend = m_single;
            3'b011:         addend = m_double;
            3'b100:         addend = -m_double;
            3'b101, 3'b110: addend = -m_single;
            default:        addend = '0;
        endcase
        sum        = acc + addend;
        acc_next   = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_next     = {sum[1:0], qreg[EW-1:2]};
        guard_next = qreg[1];
    end

    // Datapath registers: capture on start, iterate while running, publish the product on the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            acc    <= '0;
            mreg   <= '0;
            qreg   <= '0;
            qguard <= 1'b0;
            out    <= '0;
        end else if (capture) begin
            count  <= CW'(NITER);
            acc    <= '0;
            mreg   <= m_cap;
            qreg   <= q_cap;
            qguard <= 1'b0;
        end else if (iterate) begin
            count  <= count - CW'(1);
            acc    <= acc_next;
            qreg   <= q_next;
            qguard <= guard_next;
            if (last) begin
                out <= {acc_next[WIDTH-3:0], q_next};
            end
        end
    end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb_seq_booth_multiplier: directed and random checks of the Booth multiplier
// at WIDTH=32 and WIDTH=8, with expected products held in a scoreboard queue.
module tb_seq_booth_multiplier;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        start;
    logic        signed_mode;
    logic [31:0] inputM;
    logic [31:0] inputQ;
    logic        busy;
    logic        done;
    logic [63:0] out;

    logic        start8;
    logic        signed_mode8;
    logic [7:0]  inputM8;
    logic [7:0]  inputQ8;
    logic        busy8;
    logic        done8;
    logic [15:0] out8;

    int          compareCount = 0;
    int          failCount = 0;
    logic [63:0] sbq[$];
    logic [15:0] sbq8[$];
    logic [63:0] lastOut;
    int          busyCycles;

    typedef struct {
        logic [31:0] m;
        logic [31:0] q;
        logic        sm;
        logic [63:0] expected;
    } vec_t;

    vec_t directed[7];

    seq_booth_multiplier #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .en(en), .start(start), .signed_mode(signed_mode),
        .inputM(inputM), .inputQ(inputQ), .busy(busy), .done(done), .out(out)
    );

    seq_booth_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .en(en), .start(start8), .signed_mode(signed_mode8),
        .inputM(inputM8), .inputQ(inputQ8), .busy(busy8), .done(done8), .out(out8)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Independent reference: widen each operand to 64 bits and keep the low 64 bits of the product.
    function automatic logic [63:0] model32(input logic [31:0] m, input logic [31:0] q, input logic sm);
        logic [63:0] a;
        logic [63:0] b;
        a = sm ? {{32{m[31]}}, m} : {32'b0, m};
        b = sm ? {{32{q[31]}}, q} : {32'b0, q};
        return a * b;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one operation for a single edge; afterwards the operand inputs are scrambled.
    task automatic applyStimulus(input logic [31:0] m, input logic [31:0] q, input logic sm,
                                 input logic [63:0] expected, input bit track);
        @(negedge clk);
        inputM      = m;
        inputQ      = q;
        signed_mode = sm;
        start       = 1'b1;
        if (track) sbq.push_back(expected);
        @(posedge clk);
        #1;
        start  = 1'b0;
        inputM = $urandom;
        inputQ = $urandom;
    endtask

    // Waits for done, checking the product never changes early, then pops and compares.
    task automatic waitDone(input string tag, input int expCycles, output int busyCount);
        int cycles;
        bit seen;
        cycles    = 0;
        seen      = 1'b0;
        busyCount = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cycles = i;
                seen   = 1'b1;
                break;
            end
            if (busy) busyCount++;
            checkOutput({tag, "_hold"}, out, lastOut);
        end
        if (!seen) begin
            checkOutput({tag, "_timeout"}, 64'(done), 64'd1);
            if (sbq.size() > 0) void'(sbq.pop_front());
        end else if (sbq.size() == 0) begin
            checkOutput({tag, "_unexpected_done"}, 64'(done), 64'd0);
        end else begin
            logic [63:0] exp;
            exp = sbq.pop_front();
            checkOutput({tag, "_latency"}, 64'(cycles), 64'(expCycles));
            checkOutput({tag, "_product"}, out, exp);
            checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'd0);
            lastOut = exp;
        end
    endtask

    task automatic run8(input string tag, input logic [7:0] m, input logic [7:0] q,
                        input logic sm, input logic [15:0] expected);
        int cycles;
        bit seen;
        cycles = 0;
        seen   = 1'b0;
        @(negedge clk);
        inputM8      = m;
        inputQ8      = q;
        signed_mode8 = sm;
        start8       = 1'b1;
        sbq8.push_back(expected);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done8) begin
                cycles = i;
                seen   = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checkOutput({tag, "_timeout"}, 64'(done8), 64'd1);
            void'(sbq8.pop_front());
        end else begin
            checkOutput({tag, "_latency"}, 64'(cycles), 64'd5);
            checkOutput({tag, "_product"}, 64'(out8), 64'(sbq8.pop_front()));
        end
    endtask

    initial begin
        directed[0] = '{32'h00087234, 32'hFFFFFEFD, 1'b1, 64'hFFFFFFFFF7747564};
        directed[1] = '{32'h00087234, 32'hFFFFFEFD, 1'b0, 64'h00087233F7747564};
        directed[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
        directed[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
        directed[4] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
        directed[5] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h0000000080000000};
        directed[6] = '{32'h00000000, 32'h50647236, 1'b1, 64'h0000000000000000};

        reset        = 1'b1;
        en           = 1'b1;
        start        = 1'b0;
        signed_mode  = 1'b0;
        inputM       = '0;
        inputQ       = '0;
        start8       = 1'b0;
        signed_mode8 = 1'b0;
        inputM8      = '0;
        inputQ8      = '0;
        lastOut      = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out", out, 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_out8", 64'(out8), 64'd0);
        reset = 1'b0;

        // First product with latency and busy-window checks.
        applyStimulus(32'h00087234, 32'h00000348, 1'b1, 64'h000000001BB6BAA0, 1'b1);
        checkOutput("t1_busy_after_start", 64'(busy), 64'd1);
        waitDone("t1", 17, busyCycles);
        checkOutput("t1_busy_cycles", 64'(busyCycles + 1), 64'd17);
        @(posedge clk);
        #1;
        checkOutput("t1_done_pulse", 64'(done), 64'd0);
        checkOutput("t1_out_holds", out, lastOut);

        // Directed corners.
        foreach (directed[k]) begin
            applyStimulus(directed[k].m, directed[k].q, directed[k].sm, directed[k].expected, 1'b1);
            waitDone($sformatf("dir%0d", k), 17, busyCycles);
        end

        // Random operands against the reference model.
        for (int r = 0; r < 6; r++) begin
            logic [31:0] m;
            logic [31:0] q;
            logic        sm;
            m  = $urandom;
            q  = $urandom;
            sm = r[0];
            applyStimulus(m, q, sm, model32(m, q, sm), 1'b1);
            waitDone($sformatf("rnd%0d", r), 17, busyCycles);
        end

        // Stall: three disabled cycles mid-run push done out by three edges.
        applyStimulus(32'h12345678, 32'h9ABCDEF0, 1'b1, model32(32'h12345678, 32'h9ABCDEF0, 1'b1), 1'b1);
        repeat (4) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stall_busy_held", 64'(busy), 64'd1);
        en = 1'b1;
        waitDone("stall", 13, busyCycles);

        // Restart attempt mid-run is ignored.
        applyStimulus(32'h0000BEEF, 32'hFFFF0001, 1'b0, model32(32'h0000BEEF, 32'hFFFF0001, 1'b0), 1'b1);
        repeat (5) @(posedge clk);
        #1;
        inputM      = 32'h11111111;
        inputQ      = 32'h22222222;
        signed_mode = 1'b1;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone("restart", 11, busyCycles);

        // Back-to-back: second start issued in the done cycle.
        applyStimulus(32'h00087234, 32'h00000348, 1'b1, 64'h000000001BB6BAA0, 1'b1);
        waitDone("b2b_first", 17, busyCycles);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b1);
        checkOutput("b2b_done_drop", 64'(done), 64'd0);
        checkOutput("b2b_busy_rise", 64'(busy), 64'd1);
        waitDone("b2b_second", 17, busyCycles);

        // Reset in the middle of an operation after a 0x1BB6BAA0 result.
        applyStimulus(32'h00087234, 32'h00000348, 1'b1, 64'h000000001BB6BAA0, 1'b1);
        waitDone("pre_reset", 17, busyCycles);
        applyStimulus(32'h76543210, 32'h01234567, 1'b1, 64'd0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("mid_reset_out", out, 64'd0);
        checkOutput("mid_reset_busy", 64'(busy), 64'd0);
        checkOutput("mid_reset_done", 64'(done), 64'd0);
        lastOut = '0;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("post_reset_idle_done", 64'(done), 64'd0);
        checkOutput("post_reset_idle_out", out, 64'd0);
        applyStimulus(32'h00087234, 32'h00000348, 1'b0, 64'h000000001BB6BAA0, 1'b1);
        waitDone("post_reset", 17, busyCycles);

        // Narrow instance.
        run8("w8_signed", 8'h80, 8'h7F, 1'b1, 16'hC080);
        run8("w8_unsigned", 8'h80, 8'h7F, 1'b0, 16'h3F80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
